// File: rtl/ex_mem_buffer.sv
// EX->MEM elastic pipeline register: 2-entry skid buffer with registered ready,
// youngest-entry forwarding tap and a saturating back-pressure counter.
module ex_mem_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [DATA_W-1:0] ex_alu_data_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic              ex_rd_wren_i,
    input  logic [DATA_W-1:0] ex_pc_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [DATA_W-1:0] mem_alu_data_o,
    output logic [REG_AW-1:0] mem_rd_addr_o,
    output logic              mem_rd_wren_o,
    output logic [DATA_W-1:0] mem_pc_o,
    output logic              fwd_valid_o,
    output logic [REG_AW-1:0] fwd_rd_addr_o,
    output logic [DATA_W-1:0] fwd_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t state_q, state_d;
    logic ready_q, ready_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [REG_AW-1:0] main_rd_q, main_rd_d;
    logic main_wren_q, main_wren_d;
    logic [DATA_W-1:0] main_pc_q, main_pc_d;

    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [REG_AW-1:0] skid_rd_q, skid_rd_d;
    logic skid_wren_q, skid_wren_d;
    logic [DATA_W-1:0] skid_pc_q, skid_pc_d;

    logic valid;
    logic in_fire;
    logic out_fire;
    logic cap;
    logic in_wren;

    assign valid    = (state_q != EMPTY);
    assign in_fire  = ex_valid_i & ready_q;
    assign out_fire = valid & mem_ready_i;
    assign cap      = in_fire & ~flush_i;
    // x0 is hardwired, so a result aimed at it never writes back or forwards
    assign in_wren  = ex_rd_wren_i & (ex_rd_addr_i != '0);

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_rd_d   = main_rd_q;
        main_wren_d = main_wren_q;
        main_pc_d   = main_pc_q;
        skid_data_d = skid_data_q;
        skid_rd_d   = skid_rd_q;
        skid_wren_d = skid_wren_q;
        skid_pc_d   = skid_pc_q;
        stall_d     = stall_q;

        unique case (state_q)
            EMPTY: begin
                if (cap) begin
                    state_d     = ONE;
                    main_data_d = ex_alu_data_i;
                    main_rd_d   = ex_rd_addr_i;
                    main_wren_d = in_wren;
                    main_pc_d   = ex_pc_i;
                end
            end
            ONE: begin
                if (cap && out_fire) begin
                    main_data_d = ex_alu_data_i;
                    main_rd_d   = ex_rd_addr_i;
                    main_wren_d = in_wren;
                    main_pc_d   = ex_pc_i;
                end else if (cap) begin
                    state_d     = FULL;
                    skid_data_d = ex_alu_data_i;
                    skid_rd_d   = ex_rd_addr_i;
                    skid_wren_d = in_wren;
                    skid_pc_d   = ex_pc_i;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_rd_d   = skid_rd_q;
                    main_wren_d = skid_wren_q;
                    main_pc_d   = skid_pc_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (flush_i) begin
            state_d = EMPTY;
        end

        // ready is registered off the next state to keep it off the EX path
        ready_d = (state_d != FULL);

        if (valid && !mem_ready_i && !(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= EMPTY;
            ready_q     <= 1'b1;
            stall_q     <= '0;
            main_data_q <= '0;
            main_rd_q   <= '0;
            main_wren_q <= 1'b0;
            main_pc_q   <= '0;
            skid_data_q <= '0;
            skid_rd_q   <= '0;
            skid_wren_q <= 1'b0;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            stall_q     <= stall_d;
            main_data_q <= main_data_d;
            main_rd_q   <= main_rd_d;
            main_wren_q <= main_wren_d;
            main_pc_q   <= main_pc_d;
            skid_data_q <= skid_data_d;
            skid_rd_q   <= skid_rd_d;
            skid_wren_q <= skid_wren_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign ex_ready_o     = ready_q;
    assign mem_valid_o    = valid;
    assign mem_alu_data_o = main_data_q;
    assign mem_rd_addr_o  = main_rd_q;
    assign mem_rd_wren_o  = main_wren_q;
    assign mem_pc_o       = main_pc_q;
    assign stall_cnt_o    = stall_q;

    // the skid entry is younger than the head, so it wins when both are held
    assign fwd_rd_addr_o = (state_q == FULL) ? skid_rd_q : main_rd_q;
    assign fwd_data_o    = (state_q == FULL) ? skid_data_q : main_data_q;
    assign fwd_valid_o   = valid &
                           ((state_q == FULL) ? skid_wren_q : main_wren_q);

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Randomised scoreboard bench for ex_mem_buffer against a queue-based model.
module tb_ex_mem_buffer;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic ex_valid = 1'b0;
    logic ex_wren = 1'b0;
    logic mem_ready = 1'b0;
    logic [DW-1:0] ex_data = '0;
    logic [DW-1:0] ex_pc = '0;
    logic [AW-1:0] ex_rd = '0;

    logic ex_ready_o;
    logic mem_valid_o;
    logic [DW-1:0] mem_data_o;
    logic [AW-1:0] mem_rd_o;
    logic mem_wren_o;
    logic [DW-1:0] mem_pc_o;
    logic fwd_valid_o;
    logic [AW-1:0] fwd_rd_o;
    logic [DW-1:0] fwd_data_o;
    logic [CW-1:0] stall_o;

    always #5 clk = ~clk;

    ex_mem_buffer #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .flush_i(flush),
        .ex_valid_i(ex_valid),
        .ex_ready_o(ex_ready_o),
        .ex_alu_data_i(ex_data),
        .ex_rd_addr_i(ex_rd),
        .ex_rd_wren_i(ex_wren),
        .ex_pc_i(ex_pc),
        .mem_valid_o(mem_valid_o),
        .mem_ready_i(mem_ready),
        .mem_alu_data_o(mem_data_o),
        .mem_rd_addr_o(mem_rd_o),
        .mem_rd_wren_o(mem_wren_o),
        .mem_pc_o(mem_pc_o),
        .fwd_valid_o(fwd_valid_o),
        .fwd_rd_addr_o(fwd_rd_o),
        .fwd_data_o(fwd_data_o),
        .stall_cnt_o(stall_o)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] rd;
        logic          w;
        logic [DW-1:0] pc;
    } ent_t;

    ent_t exp_q[$];
    bit m_ready = 1'b1;
    int m_stall = 0;
    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // stimulus side: accepted results are pushed; flush and reset drop everything
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_ready = 1'b1;
            m_stall = 0;
        end else begin
            if (flush) begin
                exp_q.delete();
            end else if (m_ready && ex_valid) begin
                exp_q.push_back('{ex_data, ex_rd, ex_wren && (ex_rd != 0), ex_pc});
            end
            m_ready = (exp_q.size() < 2);
        end
    end

    // monitor: compares mid-cycle, pops the head that will leave at the next edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ex_ready", 64'(ex_ready_o), 64'(m_ready));
            chk("mem_valid", 64'(mem_valid_o), 64'(exp_q.size() > 0));
            chk("stall_cnt", 64'(stall_o), 64'(m_stall));
            if (exp_q.size() > 0) begin
                chk("mem_data", 64'(mem_data_o), 64'(exp_q[0].d));
                chk("mem_rd", 64'(mem_rd_o), 64'(exp_q[0].rd));
                chk("mem_wren", 64'(mem_wren_o), 64'(exp_q[0].w));
                chk("mem_pc", 64'(mem_pc_o), 64'(exp_q[0].pc));
                chk("fwd_valid", 64'(fwd_valid_o), 64'(exp_q[$].w));
                chk("fwd_rd", 64'(fwd_rd_o), 64'(exp_q[$].rd));
                chk("fwd_data", 64'(fwd_data_o), 64'(exp_q[$].d));
                if (!mem_ready && m_stall < SAT) m_stall++;
                if (mem_ready) void'(exp_q.pop_front());
            end else begin
                chk("fwd_valid_idle", 64'(fwd_valid_o), 64'(0));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        ex_data = $urandom;
        ex_rd = AW'($urandom);
        ex_wren = 1'($urandom);
        ex_pc = $urandom;
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic [AW-1:0] rd,
                         input logic w);
        ex_valid = 1'b1;
        ex_data = d;
        ex_rd = rd;
        ex_wren = w;
        ex_pc = 32'h1000 + d;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_valid", 64'(mem_valid_o), 64'(0));
        chk("rst_ex_ready", 64'(ex_ready_o), 64'(1));
        chk("rst_fwd_valid", 64'(fwd_valid_o), 64'(0));
        chk("rst_stall", 64'(stall_o), 64'(0));
        chk("rst_data", 64'(mem_data_o), 64'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc();

        // stream
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(32'h11 + i, AW'(i + 1), 1'b1);
            cyc();
        end
        idle();
        repeat (3) cyc();

        // skid
        mem_ready = 1'b0;
        drive(32'hA, 5'd3, 1'b1);
        cyc();
        drive(32'hB, 5'd4, 1'b1);
        cyc();
        idle();
        cyc();
        chk("skid_ready", 64'(ex_ready_o), 64'(0));
        chk("skid_head", 64'(mem_data_o), 64'(32'hA));
        chk("skid_fwd", 64'(fwd_data_o), 64'(32'hB));
        mem_ready = 1'b1;
        repeat (3) cyc();
        chk("skid_drain_ready", 64'(ex_ready_o), 64'(1));

        // zero register
        drive(32'hDEAD, 5'd0, 1'b1);
        mem_ready = 1'b0;
        cyc();
        idle();
        chk("zero_valid", 64'(mem_valid_o), 64'(1));
        chk("zero_wren", 64'(mem_wren_o), 64'(0));
        chk("zero_fwd", 64'(fwd_valid_o), 64'(0));
        mem_ready = 1'b1;
        repeat (2) cyc();

        // flush while full, and while holding one with a same-cycle capture
        mem_ready = 1'b0;
        drive(32'h31, 5'd1, 1'b1);
        cyc();
        drive(32'h32, 5'd2, 1'b1);
        cyc();
        drive(32'h33, 5'd3, 1'b1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        idle();
        chk("flush_valid", 64'(mem_valid_o), 64'(0));
        chk("flush_ready", 64'(ex_ready_o), 64'(1));
        drive(32'h41, 5'd1, 1'b1);
        cyc();
        drive(32'h42, 5'd2, 1'b1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        idle();
        chk("flush1_valid", 64'(mem_valid_o), 64'(0));
        mem_ready = 1'b1;
        repeat (2) cyc();

        // random traffic
        repeat (400) begin
            mem_ready = ($urandom % 4) != 0;
            flush = ($urandom % 25) == 0;
            if (($urandom % 3) != 0) drive($urandom, AW'($urandom), 1'($urandom));
            else idle();
            cyc();
        end
        flush = 1'b0;
        idle();
        mem_ready = 1'b1;
        repeat (3) cyc();

        // async reset while full
        mem_ready = 1'b0;
        drive(32'h51, 5'd1, 1'b1);
        cyc();
        drive(32'h52, 5'd2, 1'b1);
        cyc();
        idle();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(mem_valid_o), 64'(0));
        chk("arst_ready", 64'(ex_ready_o), 64'(1));
        chk("arst_fwd", 64'(fwd_valid_o), 64'(0));
        chk("arst_stall", 64'(stall_o), 64'(0));
        chk("arst_data", 64'(mem_data_o), 64'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc();
        mem_ready = 1'b1;
        drive(32'h77, 5'd7, 1'b1);
        cyc();
        idle();
        chk("post_rst_valid", 64'(mem_valid_o), 64'(1));
        chk("post_rst_data", 64'(mem_data_o), 64'(32'h77));
        cyc();

        // stall counter saturation
        mem_ready = 1'b0;
        drive(32'h88, 5'd8, 1'b1);
        cyc();
        idle();
        repeat (20) cyc();
        chk("stall_sat", 64'(stall_o), 64'(SAT));
        chk("stall_hold", 64'(mem_data_o), 64'(32'h88));
        mem_ready = 1'b1;
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
